fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle main control decoder.
- Holds the PC and fetches one word from instruction memory over a request/ready handshake.
- Presents the held instruction and its opcode field to the decoder.
- On commit, consumes the decoder's Jump/Branch/Bne outputs plus the ALU zero flag to pick the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] are ignored and forced to 00.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, high only in FETCH.
- imem_addr  out  32  fetch address, equal to pc.
- imem_ready  in  1  memory has imem_rdata valid this cycle; sampled only while imem_req=1.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  held instruction register.
- instr_valid  out  1  instr is valid and awaiting commit (HOLD state).
- opcode  out  6  instr[31:26], to the decoder's instr input.
- commit  in  1  execute has finished the held instruction; apply next PC.
- jump  in  1  from decoder.
- branch  in  1  from decoder (beq).
- bne  in  1  from decoder.
- zero  in  1  ALU zero flag.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, for link/branch use downstream.
- instr_count  out  CNT_W  number of committed instructions.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, pc={RESET_PC[31:2],2'b00}, instr=0, instr_count=0.
  - imem_req=0, instr_valid=0, opcode=0.
- State machine (Moore outputs):
  - IDLE: one cycle after reset release, then go to FETCH unconditionally.
  - FETCH: imem_req=1, imem_addr=pc, held stable.
    - imem_ready=0: stay in FETCH for any number of wait cycles.
    - imem_ready=1: instr<=imem_rdata, go to HOLD.
  - HOLD: instr_valid=1.
    - commit=0: stay in HOLD; instr and pc held.
    - commit=1: pc<=next_pc, instr_count<=instr_count+1, go to FETCH.
- Latency: imem_ready at edge N gives instr_valid=1 from cycle N+1. Commit at edge M gives imem_req=1 with the new address from cycle M+1.
  - Minimum 2 cycles per instruction.
- Next-PC rules (32-bit, modulo 2^32):
  - p4 = pc+4.
  - Branch target = p4 + (sign_extend(instr[15:0]) << 2).
  - Jump target = {p4[31:28], instr[25:0], 2'b00}.
- Next-PC priority:
  1. jump.
  2. branch & zero.
  3. bne & ~zero.
  4. p4.
  - branch & bne both high: the priority order above resolves it.
- Ignored inputs:
  - commit outside HOLD is ignored.
  - imem_ready outside FETCH is ignored.
  - jump/branch/bne/zero are sampled only on a commit cycle.
- Wrap-around:
  - pc=0xFFFF_FFFC sequential gives next pc 0x0.
  - instr_count wraps to 0 after all-ones.
- Reset mid-operation: any state returns to IDLE. An outstanding memory request is abandoned; a late imem_ready is ignored until the next FETCH.
- pc[1:0] is always 00.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants for lw, sw, R-type, addi, andi, j, beq, bne, shared with the decoder.
  - Fetch state encodings IDLE/FETCH/HOLD.
  - Word width 32.
- One combinational sub-module, fetch_next_pc.
  - Inputs: pc, instr, jump, branch, bne, zero.
  - Outputs: pc_plus4, next_pc.
  - Verified standalone.
- The FSM, registers and counter stay in fetch_unit.

Test Plan:
1. Reset release, RESET_PC=0:
   - IDLE for 1 cycle, then imem_req=1 with imem_addr=0x0.
   - imem_ready=1 with rdata 0x8C010004 gives, next cycle, instr_valid=1 and opcode=6'b100011.
2. Sequential flow:
   - commit with all controls 0 at pc 0x0 gives imem_addr=0x4 and instr_count=1.
   - From pc 0xFFFF_FFFC the next imem_addr is 0x0.
3. beq at pc 0x10, instr 0x1000FFFE:
   - branch=1, zero=1 gives next pc 0x0C.
   - zero=0 gives 0x14.
4. bne at pc 0x20, instr 0x14000003:
   - bne=1, zero=0 gives 0x30.
   - zero=1 gives 0x24.
5. j at pc 0x4000_0100, instr 0x08000040, jump=1:
   - Gives 0x4000_0100.
   - With jump=1, branch=1, zero=1 the jump target still wins.
6. Wait states and reset:
   - imem_ready held low 3 cycles: imem_req stays 1, imem_addr stable, instr_valid=0.
   - commit pulsed during FETCH has no effect.
   - reset asserted in FETCH: immediately state IDLE, pc=RESET_PC, instr_count=0, imem_req=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, opcode field values used by the decoder,
// and the fetch-stage state encoding.
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int OPC_W = 6;
  localparam int JIDX_W = 26;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: jump, then taken beq, then taken bne,
// otherwise the sequential pc+4.
module fetch_next_pc
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0]   pc,
  input  logic [JIDX_W-1:0] instr,
  input  logic              jump,
  input  logic              branch,
  input  logic              bne,
  input  logic              zero,
  output logic [XLEN-1:0]   pc_plus4,
  output logic [XLEN-1:0]   next_pc
);

  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;

  assign pc_plus4  = pc + 32'd4;
  assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign br_target = pc_plus4 + br_off;
  // jump keeps the upper nibble of the sequential address, not of pc itself
  assign j_target  = {pc_plus4[31:28], instr, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = j_target;
    end else if (branch && zero) begin
      next_pc = br_target;
    end else if (bne && !zero) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per instruction over
// a req/ready handshake and holds it for the decoder until commit.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   instr,
  output logic              instr_valid,
  output logic [OPC_W-1:0]  opcode,
  input  logic              commit,
  input  logic              jump,
  input  logic              branch,
  input  logic              bne,
  input  logic              zero,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = word_align(RESET_PC);

  fetch_state_e     state_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;
  logic [XLEN-1:0]  instr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q;
  logic             valid_q;

  fetch_next_pc u_next_pc (
    .pc       (pc_q),
    .instr    (instr_q[JIDX_W-1:0]),
    .jump     (jump),
    .branch   (branch),
    .bne      (bne),
    .zero     (zero),
    .pc_plus4 (pc_plus4),
    .next_pc  (pc_d)
  );

  // req/valid are registered alongside the state so they are glitch-free Moore outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state_q <= ST_HOLD;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (commit) begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign opcode      = instr_q[31:26];
  assign pc          = pc_q;
  assign instr_count = cnt_q;

endmodule
